// File: rtl/sr_using_t.sv
// Clocked SR flip-flop built on a T-register core: S/R are converted to a per-lane toggle enable.
// Optional macro SR_USING_T_INVALID_EN adds a registered one-cycle `invalid` flag for S=R=1 samples.
module sr_using_t #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
`ifdef SR_USING_T_INVALID_EN
  output logic [WIDTH-1:0] invalid,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Toggle only when the requested level differs from the stored one; S=R=1 never toggles.
  always_comb begin
    t   = (S & ~R & ~q_q) | (R & ~S & q_q);
    q_d = q_q ^ t;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign Qn = ~q_q;

`ifdef SR_USING_T_INVALID_EN
  logic [WIDTH-1:0] invalid_d;
  logic [WIDTH-1:0] invalid_q;

  always_comb begin
    invalid_d = S & R;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      invalid_q <= '0;
    end else begin
      invalid_q <= invalid_d;
    end
  end

  assign invalid = invalid_q;
`endif

endmodule

// File: tb/tb_sr_using_t.sv
// Directed bench for sr_using_t: a 1-lane instance and a 4-lane instance with RESET_VAL=4'b1010.
module tb_sr_using_t;

  logic       clk;
  logic       rst;
  logic       s1, r1;
  logic       q1, qn1;
  logic [3:0] s4, r4;
  logic [3:0] q4, qn4;
`ifdef SR_USING_T_INVALID_EN
  logic       inv1;
  logic [3:0] inv4;
`endif

  int total = 0;
  int bad   = 0;

  sr_using_t #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .S(s1), .R(r1),
`ifdef SR_USING_T_INVALID_EN
    .invalid(inv1),
`endif
    .Q(q1), .Qn(qn1)
  );

  sr_using_t #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
    .clk(clk), .rst(rst), .S(s4), .R(r4),
`ifdef SR_USING_T_INVALID_EN
    .invalid(inv4),
`endif
    .Q(q4), .Qn(qn4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the following rising edge.
  task automatic step1(input logic s, input logic r);
    @(negedge clk);
    s1 = s;
    r1 = r;
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input logic [3:0] s, input logic [3:0] r);
    @(negedge clk);
    s4 = s;
    r4 = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s1 = 1'b0; r1 = 1'b0;
    s4 = 4'b0000; r4 = 4'b0000;
    #2;
    check("rst_q1", {3'b0, q1}, 4'b0000);
    check("rst_qn1", {3'b0, qn1}, 4'b0001);
    check("rst_q4", q4, 4'b1010);
    check("rst_qn4", qn4, 4'b0101);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Set to 1, then assert reset mid-cycle with no clock edge.
    step1(1'b1, 1'b0);
    check("set_before_async", {3'b0, q1}, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_q", {3'b0, q1}, 4'b0000);
    check("async_rst_qn", {3'b0, qn1}, 4'b0001);
    step1(1'b1, 1'b0);
    step1(1'b1, 1'b0);
    check("rst_held_edges", {3'b0, q1}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    s1 = 1'b0;
    r1 = 1'b0;

    // Truth-table sequence from Q=0.
    step1(1'b1, 1'b0); check("seq_set", {3'b0, q1}, 4'b0001);
    step1(1'b0, 1'b0); check("seq_hold1", {3'b0, q1}, 4'b0001);
    check("seq_hold1_qn", {3'b0, qn1}, 4'b0000);
    step1(1'b0, 1'b1); check("seq_reset", {3'b0, q1}, 4'b0000);
    step1(1'b0, 1'b0); check("seq_hold0", {3'b0, q1}, 4'b0000);
    step1(1'b1, 1'b1); check("seq_both0", {3'b0, q1}, 4'b0000);

    // Repeated set on Q=1 and repeated reset on Q=0 stay put.
    step1(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step1(1'b1, 1'b0);
      check($sformatf("rep_set_%0d", i), {3'b0, q1}, 4'b0001);
    end
    step1(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step1(1'b0, 1'b1);
      check($sformatf("rep_rst_%0d", i), {3'b0, q1}, 4'b0000);
    end

    // S=R=1 while Q=1 holds.
    step1(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step1(1'b1, 1'b1);
      check($sformatf("both_hold_%0d", i), {3'b0, q1}, 4'b0001);
`ifdef SR_USING_T_INVALID_EN
      check($sformatf("invalid_hi_%0d", i), {3'b0, inv1}, 4'b0001);
`endif
    end
    step1(1'b0, 1'b0);
    check("after_both_hold", {3'b0, q1}, 4'b0001);
`ifdef SR_USING_T_INVALID_EN
    check("invalid_lo", {3'b0, inv1}, 4'b0000);
`endif

    // Four independent lanes.
    check("w4_pre", q4, 4'b1010);
    step4(4'b0101, 4'b1010); check("w4_flip", q4, 4'b0101);
    check("w4_flip_qn", qn4, 4'b1010);
    step4(4'b1100, 4'b0011); check("w4_mixed", q4, 4'b1100);
    step4(4'b1111, 4'b1111); check("w4_both", q4, 4'b1100);
`ifdef SR_USING_T_INVALID_EN
    check("w4_invalid", inv4, 4'b1111);
`endif
    step4(4'b0000, 4'b0000); check("w4_hold", q4, 4'b1100);

    // Reset asserted with a set pending just before the rising edge.
    step1(1'b0, 1'b1);
    check("pre_pending_q", {3'b0, q1}, 4'b0000);
    @(negedge clk);
    s1 = 1'b1;
    r1 = 1'b0;
    s4 = 4'b0101;
    r4 = 4'b0000;
    #4;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("pending_rst_q1", {3'b0, q1}, 4'b0000);
    check("pending_rst_q4", q4, 4'b1010);
    @(negedge clk);
    rst = 1'b0;
    s1 = 1'b0;
    s4 = 4'b0000;
    @(posedge clk);
    #1;
    check("after_pending_q1", {3'b0, q1}, 4'b0000);
    check("after_pending_q4", q4, 4'b1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
